// File: rtl/pipe_stage_fifo.sv
// Inter-stage pipeline buffer: DEPTH-entry show-ahead FIFO with valid/ready handshake,
// per-entry bubble insertion (control field zeroed), global flush and head freeze.
module pipe_stage_fifo #(
    parameter  int unsigned DATA_W = 96,
    parameter  int unsigned CTRL_W = 10,
    parameter  int unsigned DEPTH  = 2,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_kill,
    input  logic              flush,
    input  logic              freeze,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  occupancy,
    output logic [15:0]       bubble_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [DATA_W-1:0] KEEP_MASK =
        ~{{(DATA_W - CTRL_W){1'b0}}, {CTRL_W{1'b1}}};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr_nxt;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] head_nxt;
    logic [15:0]       bubble_nxt;
    logic              enq;
    logic              deq;

    // in_ready/out_valid are registered images of count, so the handshake never loops back
    assign enq = in_valid & in_ready & ~flush;
    assign deq = out_valid & out_ready & ~freeze & ~flush;

    assign wr_data   = in_kill ? (in_data & KEEP_MASK) : in_data;
    assign occupancy = count;

    // Next pointers and count; flush overrides any enqueue/dequeue
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (enq) begin
                wr_ptr_nxt = wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_nxt = rd_ptr + PTR_W'(1);
            end
            count_nxt = count + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // Next head word; the just-written entry is forwarded when it becomes the head
    always_comb begin
        head_nxt = '0;
        if (count_nxt != '0) begin
            if (enq && (wr_ptr == rd_ptr_nxt)) begin
                head_nxt = wr_data;
            end else begin
                head_nxt = mem[rd_ptr_nxt];
            end
        end
    end

    always_comb begin
        bubble_nxt = bubble_count;
        if (enq && in_kill && (bubble_count != 16'hFFFF)) begin
            bubble_nxt = bubble_count + 16'd1;
        end
    end

    // Payload storage needs no reset: out_data is masked while the buffer is empty
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_data     <= '0;
            bubble_count <= '0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            in_ready     <= (count_nxt != CNT_W'(DEPTH));
            out_valid    <= (count_nxt != '0);
            out_data     <= head_nxt;
            bubble_count <= bubble_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Scoreboard bench for pipe_stage_fifo: directed cases on a DEPTH=2 instance,
// random traffic and bubble-counter saturation on a DEPTH=4 instance.
module tb_pipe_stage_fifo;

    localparam int unsigned DW = 96;
    localparam int unsigned CW = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          in_valid2, in_kill2, flush2, freeze2, out_ready2;
    logic [DW-1:0] in_data2;
    logic          in_ready2, out_valid2;
    logic [DW-1:0] out_data2;
    logic [1:0]    occ2;
    logic [15:0]   bub2;

    logic          in_valid4, in_kill4, flush4, freeze4, out_ready4;
    logic [DW-1:0] in_data4;
    logic          in_ready4, out_valid4;
    logic [DW-1:0] out_data4;
    logic [2:0]    occ4;
    logic [15:0]   bub4;

    pipe_stage_fifo #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_kill(in_kill2),
        .flush(flush2), .freeze(freeze2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .occupancy(occ2), .bubble_count(bub2)
    );

    pipe_stage_fifo #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_kill(in_kill4),
        .flush(flush4), .freeze(freeze4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .occupancy(occ4), .bubble_count(bub4)
    );

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] exp2[$];
    logic [DW-1:0] exp4[$];
    logic [15:0]   b4;

    localparam logic [DW-1:0] A  = 96'h1111_2222_3333_4444_5555_ABCD;
    localparam logic [DW-1:0] B  = 96'h0BAD_F00D_0000_1111_2222_0001;
    localparam logic [DW-1:0] C  = 96'h0C0C_0C0C_0C0C_0C0C_0C0C_0C0C;
    localparam logic [DW-1:0] K  = 96'hDEAD_BEEF_CAFE_F00D_1234_57FF;
    localparam logic [DW-1:0] KB = 96'hDEAD_BEEF_CAFE_F00D_1234_5400;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [DW-1:0] bubble(input logic [DW-1:0] d);
        return {d[DW-1:CW], {CW{1'b0}}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one payload to the DEPTH=2 instance, holding it until accepted
    task automatic send2(input logic [DW-1:0] d, input logic k);
        bit done = 1'b0;
        in_valid2 = 1'b1;
        in_data2  = d;
        in_kill2  = k;
        for (int i = 0; i < 50 && !done; i++) begin
            if (in_ready2 && !flush2) begin
                exp2.push_back(k ? bubble(d) : d);
                done = 1'b1;
            end
            tick();
        end
        in_valid2 = 1'b0;
        in_kill2  = 1'b0;
        if (!done) timeout("send2");
    endtask

    task automatic drain2();
        for (int i = 0; i < 50 && occ2 != 2'd0; i++) tick();
        check("drain2_occ", occ2, 0);
    endtask

    task automatic drain4();
        for (int i = 0; i < 50 && occ4 != 3'd0; i++) tick();
        check("drain4_occ", occ4, 0);
    endtask

    // Monitor: pop and compare whenever a head is consumed at the coming edge
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid2 && out_ready2 && !freeze2 && !flush2) begin
                if (exp2.size() == 0) timeout("sb2_unexpected_output");
                else check("sb2_data", out_data2, exp2.pop_front());
            end
            if (out_valid4 && out_ready4 && !freeze4 && !flush4) begin
                if (exp4.size() == 0) timeout("sb4_unexpected_output");
                else check("sb4_data", out_data4, exp4.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b0;
        {in_valid2, in_kill2, flush2, freeze2, out_ready2} = '0;
        {in_valid4, in_kill4, flush4, freeze4, out_ready4} = '0;
        in_data2 = '0;
        in_data4 = '0;
        b4 = '0;
        #12;
        check("rst_occ", occ2, 0);
        check("rst_in_ready", in_ready2, 1);
        check("rst_out_valid", out_valid2, 0);
        check("rst_out_data", out_data2, 0);
        check("rst_bubble", bub2, 0);
        @(negedge clk) rst = 1'b1;
        tick();

        // T1 latency
        out_ready2 = 1'b1;
        send2(A, 1'b0);
        check("t1_out_valid", out_valid2, 1);
        check("t1_out_data", out_data2, A);
        check("t1_occ1", occ2, 1);
        tick();
        check("t1_occ0", occ2, 0);
        check("t1_empty_valid", out_valid2, 0);
        check("t1_empty_data", out_data2, 0);

        // T2 full and backpressure; out_ready must not open in_ready when full
        out_ready2 = 1'b0;
        send2(A, 1'b0);
        send2(B, 1'b0);
        check("t2_in_ready_full", in_ready2, 0);
        check("t2_occ_full", occ2, 2);
        in_valid2  = 1'b1;
        in_data2   = C;
        out_ready2 = 1'b1;
        check("t2_full_ignores_out_ready", in_ready2, 0);
        tick();
        check("t2_c_not_admitted", occ2, 1);
        send2(C, 1'b0);
        drain2();

        // T3 kill
        send2(K, 1'b1);
        check("t3_bubble_data", out_data2, KB);
        check("t3_bubble_count", bub2, 1);
        tick();
        in_kill2 = 1'b1;
        tick();
        in_kill2 = 1'b0;
        check("t3_kill_no_enq", bub2, 1);
        check("t3_kill_no_enq_occ", occ2, 0);

        // T4 flush while full with a pending enqueue
        out_ready2 = 1'b0;
        send2(A, 1'b0);
        send2(B, 1'b0);
        check("t4_full", occ2, 2);
        in_valid2 = 1'b1;
        in_data2  = C;
        flush2    = 1'b1;
        tick();
        exp2.delete();
        flush2    = 1'b0;
        in_valid2 = 1'b0;
        check("t4_occ", occ2, 0);
        check("t4_out_valid", out_valid2, 0);
        check("t4_out_data", out_data2, 0);
        check("t4_in_ready", in_ready2, 1);
        tick();
        check("t4_not_stored", occ2, 0);
        check("t4_bubble_kept", bub2, 1);

        // T5 freeze holds head while enqueue continues
        send2(A, 1'b0);
        freeze2    = 1'b1;
        out_ready2 = 1'b1;
        send2(B, 1'b0);
        check("t5_hold0", out_data2, A);
        check("t5_occ0", occ2, 2);
        tick();
        check("t5_hold1", out_data2, A);
        tick();
        check("t5_hold2", out_data2, A);
        check("t5_occ2", occ2, 2);
        freeze2 = 1'b0;
        drain2();

        // freeze together with flush: flush wins
        out_ready2 = 1'b0;
        send2(C, 1'b0);
        freeze2 = 1'b1;
        flush2  = 1'b1;
        tick();
        exp2.delete();
        freeze2 = 1'b0;
        flush2  = 1'b0;
        check("ff_occ", occ2, 0);
        check("ff_out_data", out_data2, 0);

        // Asynchronous reset mid-operation
        send2(A, 1'b0);
        send2(B, 1'b0);
        #2 rst = 1'b0;
        #1;
        exp2.delete();
        check("arst_occ", occ2, 0);
        check("arst_out_valid", out_valid2, 0);
        check("arst_out_data", out_data2, 0);
        check("arst_in_ready", in_ready2, 1);
        check("arst_bubble", bub2, 0);
        @(negedge clk) rst = 1'b1;
        tick();

        // T6 random traffic on DEPTH=4
        for (int i = 0; i < 1000; i++) begin
            in_valid4  = 1'($urandom_range(0, 1));
            in_data4   = {$urandom, $urandom, $urandom};
            in_kill4   = ($urandom_range(0, 3) == 0);
            out_ready4 = 1'($urandom_range(0, 1));
            if (in_valid4 && in_ready4) begin
                exp4.push_back(in_kill4 ? bubble(in_data4) : in_data4);
                if (in_kill4 && b4 != 16'hFFFF) b4 = b4 + 16'd1;
            end
            tick();
            tests++;
            if (occ4 > 3'd4) begin
                fails++;
                $display("FAIL t6_occ_bound: got %0d expected <= 4", occ4);
            end
        end
        in_valid4  = 1'b0;
        in_kill4   = 1'b0;
        out_ready4 = 1'b1;
        drain4();
        check("t6_bubble_model", bub4, b4);

        // Bubble counter saturation
        in_valid4 = 1'b1;
        in_kill4  = 1'b1;
        for (int i = 0; i < 70000 && b4 != 16'hFFFE; i++) begin
            in_data4 = {$urandom, $urandom, $urandom};
            if (in_ready4) begin
                exp4.push_back(bubble(in_data4));
                b4 = b4 + 16'd1;
            end
            tick();
        end
        in_valid4 = 1'b0;
        tick();
        check("t6_bubble_fffe", bub4, 16'hFFFE);
        for (int n = 0; n < 2; n++) begin
            bit done = 1'b0;
            in_valid4 = 1'b1;
            in_data4  = C;
            for (int i = 0; i < 50 && !done; i++) begin
                if (in_ready4) begin
                    exp4.push_back(bubble(C));
                    done = 1'b1;
                end
                tick();
            end
            in_valid4 = 1'b0;
            if (!done) timeout("t6_sat_send");
        end
        check("t6_bubble_sat", bub4, 16'hFFFF);
        in_kill4 = 1'b0;
        drain4();
        tick();
        check("sb2_leftover", exp2.size(), 0);
        check("sb4_leftover", exp4.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
